// File: rtl/steering_pkg.sv
// Shared definitions for the weighted steering controller.
//   state_t       : controller FSM states
//   clog2         : ceiling log2 for parameter arithmetic
//   int_w         : signed working width that cannot overflow before clamping
//   sat_to_width  : symmetric signed clamp to +/-(2^(out_w-1)-1)
package steering_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CENTER,
        RESULT
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int int_w(input int speed_w, input int weight_w, input int n);
        int a;
        a = weight_w + clog2(n + 1);
        return ((speed_w > a) ? speed_w : a) + 2;
    endfunction

    // Symmetric clamp: the most negative code is never produced, so a
    // command and its mirror always have equal magnitude.
    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] x,
                                                        input int out_w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        if (x > lim) begin
            return lim;
        end
        if (x < -lim) begin
            return -lim;
        end
        return x;
    endfunction

endpackage

// File: rtl/steering_sat.sv
// Combinational signed clamp from the controller's working width to the
// wheel command width.
//   din  : signed value, IN_W bits (IN_W < 32)
//   dout : clamped signed value, OUT_W bits
module steering_sat
    import steering_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    logic signed [31:0] wide;
    logic signed [31:0] clamped;

    assign wide    = {{(32 - IN_W){din[IN_W-1]}}, din};
    assign clamped = sat_to_width(wide, OUT_W);
    assign dout    = clamped[OUT_W-1:0];

endmodule

// File: rtl/weighted_steering_controller.sv
// Obstacle-avoidance wheel controller. Captures sensors, weights and speed,
// accumulates one left/right sensor pair per cycle, then emits saturated
// signed wheel commands with a one-cycle valid strobe.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   enable       : run when high; low aborts and zeroes outputs
//   speed        : unsigned base speed (sampled at capture)
//   sensor_array : 1 = obstacle, MSB leftmost, LSB rightmost
//   weights      : packed unsigned weights, weight i at [i*WEIGHT_W +: WEIGHT_W]
//   wheel_left   : signed left wheel command
//   wheel_right  : signed right wheel command
//   out_valid    : one-cycle strobe when new wheel values are present
//   busy         : high whenever the FSM is not IDLE
module weighted_steering_controller
    import steering_pkg::*;
#(
    parameter int SENSOR_COUNT = 5,
    parameter int WEIGHT_W     = 4,
    parameter int SPEED_W      = 4,
    parameter int OUT_W        = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [SPEED_W-1:0]                 speed,
    input  logic [SENSOR_COUNT-1:0]            sensor_array,
    input  logic [SENSOR_COUNT*WEIGHT_W-1:0]   weights,
    output logic signed [OUT_W-1:0]            wheel_left,
    output logic signed [OUT_W-1:0]            wheel_right,
    output logic                               out_valid,
    output logic                               busy
);

    localparam int HALF       = SENSOR_COUNT / 2;
    localparam bit HAS_CENTER = (SENSOR_COUNT % 2) == 1;
    localparam int INT_W      = int_w(SPEED_W, WEIGHT_W, SENSOR_COUNT);
    localparam int IDX_W      = (HALF > 1) ? clog2(HALF) : 1;

    state_t state, state_nxt;

    logic [SENSOR_COUNT-1:0]          sens_q;
    logic [SENSOR_COUNT*WEIGHT_W-1:0] w_q;
    logic [SPEED_W-1:0]               speed_q;
    logic [IDX_W-1:0]                 idx;
    logic                             last_idx;

    logic signed [INT_W-1:0] acc_l, acc_r;
    logic signed [INT_W-1:0] add_l, add_r;
    logic signed [INT_W-1:0] c_term, speed_x, diff, sum_l, sum_r;
    logic signed [OUT_W-1:0] sat_l, sat_r;

    function automatic logic signed [INT_W-1:0] ext_w(input logic [WEIGHT_W-1:0] w);
        return {{(INT_W - WEIGHT_W){1'b0}}, w};
    endfunction

    // Pair selection: right index idx and its mirrored left partner.
    always_comb begin
        add_l = '0;
        add_r = '0;
        for (int i = 0; i < HALF; i++) begin
            if (idx == IDX_W'(i)) begin
                if (sens_q[i]) begin
                    add_r = ext_w(w_q[i*WEIGHT_W +: WEIGHT_W]);
                end
                if (sens_q[SENSOR_COUNT-1-i]) begin
                    add_l = ext_w(w_q[(SENSOR_COUNT-1-i)*WEIGHT_W +: WEIGHT_W]);
                end
            end
        end
    end

    assign last_idx = (int'(idx) == HALF - 1);
    assign c_term   = (HAS_CENTER && sens_q[HALF]) ? ext_w(w_q[HALF*WEIGHT_W +: WEIGHT_W]) : '0;
    assign speed_x  = {{(INT_W - SPEED_W){1'b0}}, speed_q};
    assign diff     = acc_l - acc_r;
    assign sum_l    = speed_x + diff - c_term;
    assign sum_r    = speed_x - diff - c_term;

    steering_sat #(.IN_W(INT_W), .OUT_W(OUT_W)) u_sat_l (.din(sum_l), .dout(sat_l));
    steering_sat #(.IN_W(INT_W), .OUT_W(OUT_W)) u_sat_r (.din(sum_r), .dout(sat_r));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = (state == RESULT);
        busy      = (state != IDLE);
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = (HALF == 0) ? CENTER : ACCUM;
                ACCUM:   if (last_idx) state_nxt = CENTER;
                CENTER:  state_nxt = RESULT;
                RESULT:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Capture stage: shadow copies isolate the computation from input changes.
    always_ff @(posedge clk) begin
        if (state == IDLE && enable) begin
            sens_q  <= sensor_array;
            w_q     <= weights;
            speed_q <= speed;
        end
    end

    // Accumulate / result stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_l       <= '0;
            acc_r       <= '0;
            idx         <= '0;
            wheel_left  <= '0;
            wheel_right <= '0;
        end else if (!enable) begin
            acc_l       <= '0;
            acc_r       <= '0;
            idx         <= '0;
            wheel_left  <= '0;
            wheel_right <= '0;
        end else begin
            case (state)
                IDLE: begin
                    acc_l <= '0;
                    acc_r <= '0;
                    idx   <= '0;
                end
                ACCUM: begin
                    acc_l <= acc_l + add_l;
                    acc_r <= acc_r + add_r;
                    idx   <= idx + 1'b1;
                end
                CENTER: begin
                    wheel_left  <= sat_l;
                    wheel_right <= sat_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weighted_steering_controller.sv
// Self-checking bench: four controller builds share clock, reset, enable and
// input buses; each transaction checks one selected build against a
// side-sum reference model.
module tb_weighted_steering_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [4:0]  S;
    logic [19:0] W;
    logic [3:0]  SPD;

    logic signed [7:0] wl0, wr0, wl2, wr2, wl3, wr3;
    logic signed [4:0] wl1, wr1;
    logic v0, v1, v2, v3, b0, b1, b2, b3;

    int sel;
    logic signed [31:0] obs_l, obs_r, obs_v, obs_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    weighted_steering_controller #(.SENSOR_COUNT(5), .WEIGHT_W(4), .SPEED_W(4), .OUT_W(8)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .speed(SPD), .sensor_array(S), .weights(W),
        .wheel_left(wl0), .wheel_right(wr0), .out_valid(v0), .busy(b0));
    weighted_steering_controller #(.SENSOR_COUNT(5), .WEIGHT_W(4), .SPEED_W(4), .OUT_W(5)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .speed(SPD), .sensor_array(S), .weights(W),
        .wheel_left(wl1), .wheel_right(wr1), .out_valid(v1), .busy(b1));
    weighted_steering_controller #(.SENSOR_COUNT(1), .WEIGHT_W(4), .SPEED_W(4), .OUT_W(8)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .speed(SPD), .sensor_array(S[0:0]), .weights(W[3:0]),
        .wheel_left(wl2), .wheel_right(wr2), .out_valid(v2), .busy(b2));
    weighted_steering_controller #(.SENSOR_COUNT(2), .WEIGHT_W(4), .SPEED_W(4), .OUT_W(8)) dut3 (
        .clk(clk), .reset(reset), .enable(enable), .speed(SPD), .sensor_array(S[1:0]), .weights(W[7:0]),
        .wheel_left(wl3), .wheel_right(wr3), .out_valid(v3), .busy(b3));

    always_comb begin
        obs_l = '0;
        obs_r = '0;
        obs_v = '0;
        obs_b = '0;
        case (sel)
            0: begin obs_l = 32'(wl0); obs_r = 32'(wr0); obs_v = {31'd0, v0}; obs_b = {31'd0, b0}; end
            1: begin obs_l = 32'(wl1); obs_r = 32'(wr1); obs_v = {31'd0, v1}; obs_b = {31'd0, b1}; end
            2: begin obs_l = 32'(wl2); obs_r = 32'(wr2); obs_v = {31'd0, v2}; obs_b = {31'd0, b2}; end
            default: begin obs_l = 32'(wl3); obs_r = 32'(wr3); obs_v = {31'd0, v3}; obs_b = {31'd0, b3}; end
        endcase
    end

    function automatic int cfg_n(input int which);
        return (which <= 1) ? 5 : ((which == 2) ? 1 : 2);
    endfunction

    function automatic int cfg_ow(input int which);
        return (which == 1) ? 5 : 8;
    endfunction

    // Reference: sum weights of obstacle sensors on each side, clamp.
    function automatic void model(input int n, input logic [4:0] s, input logic [19:0] w,
                                  input int spd, input int ow, output int el, output int er);
        int h, l, r, c, wi, lim;
        h = n / 2; l = 0; r = 0; c = 0;
        for (int i = 0; i < n; i++) begin
            wi = int'(w[i*4 +: 4]);
            if (s[i]) begin
                if (i < h) r += wi;
                else if (i >= n - h) l += wi;
                else c += wi;
            end
        end
        lim = (1 << (ow - 1)) - 1;
        el = spd + (l - r) - c;
        er = spd - (l - r) - c;
        if (el > lim) el = lim;
        if (el < -lim) el = -lim;
        if (er > lim) er = lim;
        if (er < -lim) er = -lim;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with all builds idle and inputs already set.
    task automatic run_txn(input int which, input bit hold, input bit scramble);
        int n, ow, h, el, er, el2, er2;
        n = cfg_n(which); ow = cfg_ow(which); h = n / 2;
        sel = which;
        model(n, S, W, int'(SPD), ow, el, er);
        enable = 1'b1;
        for (int k = 1; k <= h + 2; k++) begin
            @(negedge clk);
            if (k == 1 && scramble) begin
                S = 5'($urandom); W = 20'($urandom); SPD = 4'($urandom);
            end
            if (k < h + 2) chk("no_early_valid", obs_v, 0);
        end
        chk("valid", obs_v, 1);
        chk("left", obs_l, el);
        chk("right", obs_r, er);
        if (hold) begin
            model(n, S, W, int'(SPD), ow, el2, er2);
            for (int k = 1; k <= h + 3; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    chk("hold_left", obs_l, el);
                    chk("hold_right", obs_r, er);
                end
                if (k < h + 3) chk("no_valid_between", obs_v, 0);
            end
            chk("valid_repeat", obs_v, 1);
            chk("left_repeat", obs_l, el2);
            chk("right_repeat", obs_r, er2);
        end
        enable = 1'b0;
        @(negedge clk);
        chk("off_valid", obs_v, 0);
        chk("off_left", obs_l, 0);
        chk("off_right", obs_r, 0);
        chk("off_busy", obs_b, 0);
    endtask

    initial begin
        sel = 0; reset = 1'b0; enable = 1'b0;
        S = '0; W = 20'h42324; SPD = 4'd10;
        repeat (2) @(negedge clk);
        chk("rst_left", obs_l, 0);
        chk("rst_right", obs_r, 0);
        chk("rst_valid", obs_v, 0);
        chk("rst_busy", obs_b, 0);
        reset = 1'b1;
        @(negedge clk);

        // Clear path, with recurrence
        S = 5'b00000; SPD = 4'd10; run_txn(0, 1'b1, 1'b0);
        // Left / center / right obstacles
        S = 5'b10000; SPD = 4'd10; run_txn(0, 1'b0, 1'b1);
        S = 5'b00100; SPD = 4'd10; W = 20'h42324; run_txn(0, 1'b0, 1'b1);
        S = 5'b00011; SPD = 4'd0;  W = 20'h42324; run_txn(0, 1'b0, 1'b1);
        // Saturation on the narrow-output build
        S = 5'b11000; SPD = 4'd15; W = 20'hFFFFF; run_txn(1, 1'b0, 1'b0);
        S = 5'b11111; SPD = 4'd15; W = 20'hFFFFF; run_txn(1, 1'b0, 1'b0);

        // Abort during the second ACCUM cycle of a repeat capture
        sel = 0; S = 5'b10000; SPD = 4'd10; W = 20'h42324;
        enable = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 4) begin
                chk("abort_pre_valid", obs_v, 1);
                chk("abort_pre_left", obs_l, 14);
            end
        end
        enable = 1'b0;
        @(negedge clk);
        chk("abort_left", obs_l, 0);
        chk("abort_right", obs_r, 0);
        chk("abort_valid", obs_v, 0);
        chk("abort_busy", obs_b, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_strobe", obs_v, 0);
        end
        S = 5'b00011; SPD = 4'd0; run_txn(0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of CENTER
        sel = 0; S = 5'b10000; SPD = 4'd10; W = 20'h42324;
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) @(negedge clk);
        chk("rst_mid_pre_left", obs_l, 14);
        chk("rst_mid_pre_busy", obs_b, 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_left", obs_l, 0);
        chk("rst_mid_right", obs_r, 0);
        chk("rst_mid_valid", obs_v, 0);
        chk("rst_mid_busy", obs_b, 0);
        enable = 1'b0;
        #1 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_no_strobe", obs_v, 0);
        end

        // One- and two-sensor builds
        S = 5'b00001; W = 20'h42324; SPD = 4'd10; run_txn(2, 1'b1, 1'b0);
        S = 5'b00010; W = 20'h42324; SPD = 4'd10; run_txn(3, 1'b1, 1'b0);
        S = 5'b00001; W = 20'h42324; SPD = 4'd10; run_txn(3, 1'b0, 1'b1);

        // Randomized transactions across all builds
        for (int t = 0; t < 24; t++) begin
            S = 5'($urandom); W = 20'($urandom); SPD = 4'($urandom);
            run_txn(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
